// File: rtl/rbm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rbm_pkg : shared types and arithmetic helpers for rbm_layer_mac    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rbm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] c_sel_weight = 2'd0;
  localparam logic [1:0] c_sel_bias   = 2'd1;
  localparam logic [1:0] c_sel_seed   = 2'd2;

  // Right-shift Galois masks giving maximal-length sequences.
  function automatic int lfsr_taps(input int width);
    case (width)
      3:       return 'h6;
      4:       return 'hC;
      5:       return 'h14;
      6:       return 'h30;
      7:       return 'h60;
      8:       return 'hB8;
      9:       return 'h110;
      10:      return 'h240;
      11:      return 'h500;
      12:      return 'hE08;
      13:      return 'h1C80;
      14:      return 'h3802;
      15:      return 'h6000;
      16:      return 'hD008;
      default: return 'hB8;
    endcase
  endfunction

  // Symmetric clamp: the most negative code is never produced.
  function automatic int sat_add(input int a, input int b, input int w);
    int lim;
    int s;
    lim = (1 << (w - 1)) - 1;
    s   = a + b;
    if (s > lim)  return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

  function automatic int sigmoid(input int acc, input int sh, input int sw);
    int v;
    v = (acc >>> sh) + (1 << (sw - 1));
    if (v < 0)               return 0;
    if (v > (1 << sw) - 1)   return (1 << sw) - 1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rbm_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rbm_lfsr : Galois LFSR with seed load and advance enable           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rbm_lfsr
  import rbm_pkg::*;
#(
  parameter int SIG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [SIG_W-1:0] i_seed,
  input  logic             i_adv,
  output logic [SIG_W-1:0] o_value
);

  localparam logic [SIG_W-1:0] c_taps = SIG_W'(lfsr_taps(SIG_W));

  logic [SIG_W-1:0] r_state;
  logic [SIG_W-1:0] w_shift;

  assign w_shift = r_state[0] ? ((r_state >> 1) ^ c_taps) : (r_state >> 1);

  // An all-zero state would lock up, so a zero seed is promoted to 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= SIG_W'(1);
    end else if (i_load) begin
      r_state <= (i_seed == '0) ? SIG_W'(1) : i_seed;
    end else if (i_adv) begin
      r_state <= w_shift;
    end
  end

  assign o_value = r_state;

endmodule
`default_nettype wire

// File: rtl/rbm_layer_mac.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rbm_layer_mac : stochastic RBM layer, LANES saturating MACs        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rbm_layer_mac #(
  parameter  int W       = 12,
  parameter  int SIG_W   = 8,
  parameter  int IN_DIM  = 16,
  parameter  int OUT_DIM = 8,
  parameter  int LANES   = 2,
  parameter  int SIG_SH  = 3,
  localparam int RW      = (IN_DIM > 1) ? $clog2(IN_DIM) : 1,
  localparam int CW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [IN_DIM-1:0]  in_data,
  input  logic               stoch,
  input  logic               wr_en,
  input  logic [1:0]         wr_sel,
  input  logic [RW-1:0]      wr_row,
  input  logic [CW-1:0]      wr_col,
  input  logic [W-1:0]       wr_data,
  output logic               busy,
  output logic               done,
  output logic [OUT_DIM-1:0] out_data
);

  import rbm_pkg::*;

  localparam int NG = (OUT_DIM + LANES - 1) / LANES;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [SIG_W-1:0] c_half = SIG_W'(1 << (SIG_W - 1));

  state_t              r_state;
  state_t              w_state_nxt;
  logic [RW-1:0]       r_k;
  logic [GW-1:0]       r_g;
  logic [IN_DIM-1:0]   r_in;
  logic                r_stoch;
  logic [OUT_DIM-1:0]  r_out;
  logic signed [W-1:0] r_weight [IN_DIM][OUT_DIM];
  logic signed [W-1:0] r_bias   [OUT_DIM];

  logic                w_accept;
  logic                w_wr;
  logic                w_last_k;
  logic                w_last_g;
  logic                w_load;
  logic                w_busy;
  logic                w_done;
  logic [LANES-1:0]    w_bit;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_wr     = wr_en && !w_busy;
  assign w_last_k = (r_k == RW'(IN_DIM - 1));
  assign w_last_g = (r_g == GW'(NG - 1));
  assign w_load   = w_accept || (r_state == SAMPLE && !w_last_g);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ACC;
      end
      ACC: begin
        w_busy = 1'b1;
        if (w_last_k) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        w_busy      = 1'b1;
        w_state_nxt = w_last_g ? DONE : ACC;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = start ? ACC : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_k     <= '0;
      r_g     <= '0;
      r_in    <= '0;
      r_stoch <= 1'b0;
      r_out   <= '0;
    end else if (w_accept) begin
      r_in    <= in_data;
      r_stoch <= stoch;
      r_out   <= '0;
      r_k     <= '0;
      r_g     <= '0;
    end else if (r_state == ACC) begin
      r_k <= w_last_k ? '0 : r_k + 1'b1;
    end else if (r_state == SAMPLE) begin
      for (int l = 0; l < LANES; l++) begin
        if (int'(r_g) * LANES + l < OUT_DIM)
          r_out[CW'(int'(r_g) * LANES + l)] <= w_bit[l];
      end
      if (!w_last_g) r_g <= r_g + 1'b1;
    end
  end

  // Parameter memories are deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      case (wr_sel)
        c_sel_weight: r_weight[wr_row][wr_col] <= wr_data;
        c_sel_bias:   r_bias[wr_col]           <= wr_data;
        default:      ;
      endcase
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [W-1:0] r_acc;
    logic signed [W-1:0] w_wt;
    logic signed [W-1:0] w_add;
    logic signed [W-1:0] w_acc_sum;
    logic signed [W-1:0] w_bias_ld;
    logic [SIG_W-1:0]    w_sig;
    logic [SIG_W-1:0]    w_rnd;
    logic [SIG_W-1:0]    w_cmp;
    logic [CW-1:0]       w_col;
    logic [CW-1:0]       w_ld_col;
    logic                w_col_ok;
    logic                w_ld_ok;
    logic                w_seed_ld;
    int                  w_col_i;
    int                  w_ld_i;

    // Column being accumulated now, and column of the group about to load.
    always_comb begin
      w_col_i  = int'(r_g) * LANES + l;
      w_ld_i   = (r_state == SAMPLE) ? w_col_i + LANES : l;
      w_col_ok = (w_col_i < OUT_DIM);
      w_ld_ok  = (w_ld_i < OUT_DIM);
      w_col    = CW'(w_col_i);
      w_ld_col = CW'(w_ld_i);
    end

    assign w_wt      = w_col_ok ? r_weight[r_k][w_col] : '0;
    assign w_add     = r_in[r_k] ? w_wt : '0;
    assign w_acc_sum = W'(sat_add(int'(r_acc), int'(w_add), W));

    // A bias written in the same cycle as start is forwarded into the pass.
    always_comb begin
      w_bias_ld = '0;
      if (w_ld_ok) begin
        if (w_wr && wr_sel == c_sel_bias && wr_col == w_ld_col) w_bias_ld = wr_data;
        else                                                     w_bias_ld = r_bias[w_ld_col];
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset)                 r_acc <= '0;
      else if (w_load)           r_acc <= w_bias_ld;
      else if (r_state == ACC)   r_acc <= w_acc_sum;
    end

    assign w_sig     = SIG_W'(sigmoid(int'(r_acc), SIG_SH, SIG_W));
    assign w_cmp     = r_stoch ? w_rnd : c_half;
    assign w_bit[l]  = (w_sig > w_cmp);
    assign w_seed_ld = w_wr && (wr_sel == c_sel_seed) && (wr_col == CW'(l));

    rbm_lfsr #(
      .SIG_W (SIG_W)
    ) u_lfsr (
      .clock   (clock),
      .reset   (reset),
      .i_load  (w_seed_ld),
      .i_seed  (wr_data[SIG_W-1:0]),
      .i_adv   (r_state == SAMPLE && r_stoch),
      .o_value (w_rnd)
    );
  end

  assign busy     = w_busy;
  assign done     = w_done;
  assign out_data = r_out;

endmodule
`default_nettype wire
